// File: rtl/glyph_writer8x8_pkg.sv
// Shared font constants: glyph store size, writer commands, writer states.
// Also imported by the character generator, which reads the same address layout.
package glyph_writer8x8_pkg;

  localparam int FONT_ENTRIES = 16384;
  localparam int ADDR_W       = 14;

  typedef enum logic [1:0] {
    CMD_MONO  = 2'b00,
    CMD_ALPHA = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ROW   = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

endpackage

// File: rtl/glyph_writer8x8.sv
// Glyph store writer: expands one 8-pixel row command into eight alpha writes,
// or sweeps the whole store to zero. Addresses are {char, row, column}.
module glyph_writer8x8 #(
  parameter int FONT_ENTRIES = glyph_writer8x8_pkg::FONT_ENTRIES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_cmd,
  input  logic [7:0]  i_char,
  input  logic [2:0]  i_row,
  input  logic [23:0] i_data,
  output logic        o_we,
  output logic [13:0] o_addr,
  output logic [2:0]  o_wdata,
  output logic        o_busy
);

  import glyph_writer8x8_pkg::*;

  localparam logic [13:0] LAST = 14'(FONT_ENTRIES - 1);

  state_e      r_state, w_next;
  cmd_e        r_cmd;
  logic [7:0]  r_char;
  logic [2:0]  r_row;
  logic [23:0] r_data;
  logic [2:0]  r_col, w_col;
  logic [13:0] r_clr, w_clr;
  logic        r_we, w_we;
  logic [13:0] r_addr, w_addr;
  logic [2:0]  r_wdata, w_wdata;
  logic        r_busy;
  logic        w_ready;
  logic        w_acc;

  function automatic logic [2:0] expand(
    input cmd_e        cmd,
    input logic [23:0] d,
    input logic [2:0]  c
  );
    logic [4:0] lo;
    lo = 5'd21 - 5'd3 * {2'b00, c};
    if (cmd == CMD_MONO)
      return d[{2'b00, 3'd7 - c}] ? 3'd7 : 3'd0;
    return d[lo +: 3];
  endfunction

  // Ready only from state: the last write of a sequence overlaps acceptance.
  assign w_ready = (r_state == ST_IDLE)
                 | ((r_state == ST_ROW) && (r_col == 3'd7))
                 | ((r_state == ST_CLEAR) && (r_clr == LAST));
  assign w_acc   = i_valid && w_ready;

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_col   = r_col;
    w_clr   = r_clr;
    unique case (r_state)
      ST_IDLE: ;
      ST_ROW: begin
        if (r_col != 3'd7) begin
          w_col   = r_col + 3'd1;
          w_we    = 1'b1;
          w_addr  = {r_char, r_row, w_col};
          w_wdata = expand(r_cmd, r_data, w_col);
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (r_clr != LAST) begin
          w_clr   = r_clr + 14'd1;
          w_we    = 1'b1;
          w_addr  = w_clr;
          w_wdata = 3'd0;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_acc) begin
      unique case (i_cmd)
        CMD_MONO, CMD_ALPHA: begin
          w_next  = ST_ROW;
          w_col   = 3'd0;
          w_we    = 1'b1;
          w_addr  = {i_char, i_row, 3'd0};
          w_wdata = expand(cmd_e'(i_cmd), i_data, 3'd0);
        end
        CMD_CLEAR: begin
          w_next  = ST_CLEAR;
          w_clr   = 14'd0;
          w_we    = 1'b1;
          w_addr  = 14'd0;
          w_wdata = 3'd0;
        end
        default: begin
          w_next = ST_IDLE;
          w_we   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_MONO;
      r_char  <= '0;
      r_row   <= '0;
      r_data  <= '0;
      r_col   <= '0;
      r_clr   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_col   <= w_col;
      r_clr   <= w_clr;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_busy  <= (w_next != ST_IDLE);
      if (w_acc) begin
        r_cmd  <= cmd_e'(i_cmd);
        r_char <= i_char;
        r_row  <= i_row;
        r_data <= i_data;
      end
    end
  end

  assign o_ready = w_ready;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_glyph_writer8x8.sv
// Scoreboard bench for glyph_writer8x8: expected writes queued at acceptance,
// popped and compared as o_we strobes appear.
module tb_glyph_writer8x8;

  localparam int LIM = 20000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_cmd = '0;
  logic [7:0]  i_char = '0;
  logic [2:0]  i_row = '0;
  logic [23:0] i_data = '0;
  logic        o_ready;
  logic        o_we;
  logic [13:0] o_addr;
  logic [2:0]  o_wdata;
  logic        o_busy;

  typedef struct packed {
    logic        rdy;
    logic [13:0] addr;
    logic [2:0]  wd;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_err = 0;
  int          run = 0;
  int          max_run = 0;
  logic [13:0] last_addr = '0;
  logic [2:0]  last_wd = '0;

  always #5 i_clk = ~i_clk;

  glyph_writer8x8 dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_cmd   (i_cmd),
    .i_char  (i_char),
    .i_row   (i_row),
    .i_data  (i_data),
    .o_we    (o_we),
    .o_addr  (o_addr),
    .o_wdata (o_wdata),
    .o_busy  (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [1:0] cmd,
                                       input logic [23:0] d, input int c);
    logic [23:0] s;
    if (cmd == 2'b00) begin
      s = d >> (7 - c);
      return s[0] ? 3'd7 : 3'd0;
    end
    s = d >> (21 - 3 * c);
    return s[2:0];
  endfunction

  task automatic push(input logic [1:0] cmd, input logic [7:0] ch,
                      input logic [2:0] row, input logic [23:0] d);
    if (cmd == 2'b00 || cmd == 2'b01) begin
      for (int c = 0; c < 8; c++)
        sb.push_back({c == 7, ch, row, 3'(c), model(cmd, d, c)});
    end else if (cmd == 2'b10) begin
      for (int a = 0; a < 16384; a++)
        sb.push_back({a == 16383, 14'(a), 3'd0});
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] ch,
                      input logic [2:0] row, input logic [23:0] d);
    int t;
    t = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_cmd   = cmd;
    i_char  = ch;
    i_row   = row;
    i_data  = d;
    while (!o_ready && t < LIM) begin
      @(negedge i_clk);
      t++;
    end
    chk("accept_wait", 32'(t < LIM), 1);
    @(posedge i_clk);
    push(cmd, ch, row, d);
  endtask

  // Scramble the inputs after acceptance: held copies must be used.
  task automatic drop();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_cmd   = 2'($urandom);
    i_char  = 8'($urandom);
    i_row   = 3'($urandom);
    i_data  = 24'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < LIM) begin
      @(negedge i_clk);
      t++;
    end
    @(negedge i_clk);
    chk("drain", sb.size(), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_we", 32'(o_we), 0);
    chk("idle_ready", 32'(o_ready), 1);
    chk("hold_addr", 32'(o_addr), 32'(last_addr));
    chk("hold_wdata", 32'(o_wdata), 32'(last_wd));
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_we) begin
      run++;
      if (run > max_run) max_run = run;
      last_addr = o_addr;
      last_wd   = o_wdata;
      if (sb.size() == 0) begin
        chk("unexp_we", 32'(o_we), 0);
      end else begin
        e = sb.pop_front();
        chk("wr", {14'b0, o_ready, o_addr, o_wdata}, {14'b0, e});
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    int t;
    #1 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_we", 32'(o_we), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_wdata", 32'(o_wdata), 0);
    chk("rst_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 1);

    send(2'b00, 8'h41, 3'd3, 24'h0000A5);
    drop();
    drain();

    send(2'b01, 8'hFF, 3'd7, 24'hFAC688);
    drop();
    drain();

    max_run = 0;
    send(2'b00, 8'h12, 3'd1, 24'hFF00C3);
    send(2'b00, 8'h13, 3'd6, 24'h00005A);
    drop();
    drain();
    chk("b2b_run", max_run, 16);

    for (int k = 0; k < 6; k++) begin
      send(2'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
           24'($urandom));
      drop();
      drain();
    end

    send(2'b11, 8'h20, 3'd2, 24'h123456);
    drop();
    repeat (10) @(negedge i_clk);
    chk("rsvd_ready", 32'(o_ready), 1);
    chk("rsvd_busy", 32'(o_busy), 0);

    send(2'b10, 8'h00, 3'd0, 24'h0);
    drop();
    drain();

    send(2'b10, 8'h00, 3'd0, 24'h0);
    drop();
    t = 0;
    while (!(o_we && o_addr == 14'd100) && t < LIM) begin
      @(negedge i_clk);
      t++;
    end
    chk("clr_reach100", 32'(o_addr), 100);
    i_rst = 1'b1;
    #1;
    chk("midrst_we", 32'(o_we), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_addr", 32'(o_addr), 0);
    sb.delete();
    last_addr = '0;
    last_wd   = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("postrst_ready", 32'(o_ready), 1);
    chk("postrst_we", 32'(o_we), 0);

    send(2'b01, 8'h7E, 3'd4, 24'h2468AC);
    drop();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
